// File: rtl/alu_dot_sequencer_pkg.sv
// alu_dot_sequencer_pkg
//   Shared definitions for the dot-product sequencer and anything that talks
//   to the 24-bit combinational ALU it drives.
//   Contents:
//     DATA_W       - ALU data path width (24)
//     ALU_* codes  - ALU opcodes: ADD=0, MUL=1, SUB=2, SFTR=3, SFTL=4
//     FIXED_SHIFT  - right-shift amount used to rescale Q.8 products
//     seq_state_e  - sequencer state encoding
package alu_dot_sequencer_pkg;

  localparam int DATA_W = 24;
  localparam int CTRL_W = 3;

  localparam logic [CTRL_W-1:0] ALU_ADD  = 3'd0;
  localparam logic [CTRL_W-1:0] ALU_MUL  = 3'd1;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 3'd2;
  localparam logic [CTRL_W-1:0] ALU_SFTR = 3'd3;
  localparam logic [CTRL_W-1:0] ALU_SFTL = 3'd4;

  // A Q.8 x Q.8 product carries 16 fraction bits; shifting right by 8
  // brings it back to Q.8 before it is accumulated.
  localparam logic [DATA_W-1:0] FIXED_SHIFT = 24'd8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_MUL   = 3'd2,
    ST_SHR   = 3'd3,
    ST_ADD   = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_e;

endpackage

// File: rtl/alu_dot_sequencer.sv
// alu_dot_sequencer
//   Computes one dot product per command, sum(a[i]*b[i]) for i = 0..len-1,
//   by driving an external combinational 24-bit ALU: a MUL per element,
//   optionally an SFTR rescale, then an ADD into the running accumulator.
//   Accumulation wraps modulo 2^24.
//   Ports:
//     clk, rst_n                  - clock, asynchronous active-low reset
//     cmd_valid/cmd_ready/cmd_len - command stream (element count)
//     elem_valid/elem_ready       - operand pair stream
//     elem_a, elem_b              - left / right operands
//     alu_ctrl, alu_a, alu_b      - registered ALU opcode and operands
//     alu_c, alu_z                - ALU result and zero flag (combinational)
//     res_valid/res_ready         - result stream
//     res_data, res_zero          - accumulated dot product and its zero flag
module alu_dot_sequencer
  import alu_dot_sequencer_pkg::*;
#(
  parameter int LEN_W       = 5,
  parameter bit FIXED_POINT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              elem_valid,
  output logic              elem_ready,
  input  logic [DATA_W-1:0] elem_a,
  input  logic [DATA_W-1:0] elem_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_z,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_zero
);

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] prod_q, prod_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic              elem_ready_q, elem_ready_d;
  logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_zero_q, res_zero_d;

  // Next-state logic for the whole sequencer. Everything holds by default,
  // so the ALU operands stay put while waiting in FETCH, IDLE or DONE and the
  // ALU result is only looked at in the cycle after the operands that
  // produced it were registered. The ALU is only ever asked for MUL, SFTR
  // and ADD.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    prod_d       = prod_q;
    count_d      = count_q;
    elem_ready_d = elem_ready_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_zero_d   = res_zero_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          count_d = cmd_len;
          acc_d   = '0;
          // An empty dot product is answered straight away with zero.
          if (cmd_len == '0) begin
            res_data_d  = '0;
            res_zero_d  = 1'b1;
            res_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            elem_ready_d = 1'b1;
            state_d      = ST_FETCH;
          end
        end
      end

      ST_FETCH: begin
        if (elem_valid) begin
          elem_ready_d = 1'b0;
          alu_ctrl_d   = ALU_MUL;
          alu_a_d      = elem_a;
          alu_b_d      = elem_b;
          state_d      = ST_MUL;
        end
      end

      ST_MUL: begin
        // alu_c is the low 24 bits of the product; upper bits are lost.
        prod_d = alu_c;
        if (FIXED_POINT) begin
          alu_ctrl_d = ALU_SFTR;
          alu_a_d    = alu_c;
          alu_b_d    = FIXED_SHIFT;
          state_d    = ST_SHR;
        end else begin
          alu_ctrl_d = ALU_ADD;
          alu_a_d    = acc_q;
          alu_b_d    = alu_c;
          state_d    = ST_ADD;
        end
      end

      ST_SHR: begin
        prod_d     = alu_c;
        alu_ctrl_d = ALU_ADD;
        alu_a_d    = acc_q;
        alu_b_d    = alu_c;
        state_d    = ST_ADD;
      end

      ST_ADD: begin
        acc_d   = alu_c;
        count_d = count_q - LEN_W'(1);
        if (count_q == LEN_W'(1)) begin
          res_data_d  = alu_c;
          res_zero_d  = alu_z;
          res_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          elem_ready_d = 1'b1;
          state_d      = ST_FETCH;
        end
      end

      ST_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Reset drops any partial accumulation and
  // suppresses the pending result immediately, without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      prod_q       <= '0;
      count_q      <= '0;
      elem_ready_q <= 1'b0;
      alu_ctrl_q   <= ALU_ADD;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      prod_q       <= prod_d;
      count_q      <= count_d;
      elem_ready_q <= elem_ready_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_zero_q   <= res_zero_d;
    end
  end

  // cmd_ready is a plain decode of IDLE so it is already high in reset.
  assign cmd_ready  = (state_q == ST_IDLE);
  assign elem_ready = elem_ready_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_zero   = res_zero_q;

endmodule

// File: doc/alu_dot_sequencer.md
Name: alu_dot_sequencer

Overview:
- Issuing side of the 24-bit ALU interface: drives opcode and both operands, consumes result and zero flag.
- Computes one dot product per command: sum of a[i]*b[i] for i = 0..len-1.
- Issues MUL then ADD per element, with an optional SFTR rescale between them.
- Sits between the matrix-multiply controller (command/element streams) and the combinational ALU.

Parameters:
- LEN_W, 5, width of the element-count field; max length is 2^LEN_W-1.
- FIXED_POINT, 0, when 1 each product is shifted right 8 (SFTR) before accumulation (Q.8 operands).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer accepts command
- cmd_len  in  LEN_W  number of elements in this dot product
- elem_valid  in  1  operand pair offered
- elem_ready  out  1  operand pair accepted
- elem_a  in  24  left operand
- elem_b  in  24  right operand
- alu_ctrl  out  3  ALU opcode: ADD=0, MUL=1, SUB=2, SFTR=3, SFTL=4
- alu_a  out  24  ALU operand A
- alu_b  out  24  ALU operand B
- alu_c  in  24  ALU result (combinational from alu_ctrl/alu_a/alu_b)
- alu_z  in  1  ALU zero flag
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_data  out  24  accumulated dot product
- res_zero  out  1  res_data == 0

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, acc=0, prod=0, count=0, res_valid=0, res_data=0, res_zero=0, elem_ready=0, alu_ctrl=ADD(0), alu_a=0, alu_b=0.
- cmd_ready is decoded as (state==IDLE), so it is 1 during and after reset.
- All ALU-side outputs and res_* outputs are registered. alu_c and alu_z are sampled at the clock edge after the cycle the registered outputs are presented.
- Handshakes: a transfer occurs when valid && ready on a rising edge. valid must not depend on ready.
- States:
  - IDLE: cmd_ready=1. On cmd transfer: latch cmd_len into count and clear acc. If cmd_len==0, go to DONE with res_data=0, res_zero=1. Otherwise go to FETCH.
  - FETCH: elem_ready=1. On elem transfer: present alu_ctrl=MUL, alu_a=elem_a, alu_b=elem_b; go to MUL. elem_ready drops in the cycle after the transfer.
  - MUL: capture prod=alu_c, i.e. the low 24 bits of the product, with overflow silently truncated. If FIXED_POINT: present SFTR with alu_a=alu_c and go to SHR. Else: present ADD with alu_a=acc, alu_b=alu_c and go to ADD.
  - SHR: capture prod=alu_c. Present ADD with alu_a=acc, alu_b=alu_c; go to ADD.
  - ADD: capture acc=alu_c and decrement count. If count was 1: load res_data=alu_c, res_zero=alu_z, res_valid=1, go to DONE. Else go to FETCH.
  - DONE: hold res_valid and res_data until res_ready. On transfer: res_valid=0, go to IDLE.
- Accumulation wraps modulo 2^24; there is no saturation or overflow flag.
- Throughput:
  - Per element: 3 cycles (FETCH+MUL+ADD) with FIXED_POINT=0, 4 with FIXED_POINT=1, assuming elem_valid is held high.
  - Command latency from cmd accept to res_valid: 1 + N*3 cycles, or 1 + N*4 with FIXED_POINT=1.
- Back-to-back: a new command is accepted only in IDLE, i.e. one cycle after result consumption.
- In FETCH the ALU outputs hold their previous values. The ALU is never given SUB or SFTL.
- Reset mid-operation: immediately returns to reset values. Partial accumulation is discarded and no result is emitted.
- cmd_valid during a busy state is ignored (cmd_ready=0). elem_valid outside FETCH is not consumed.
- A stalled elem_valid holds FETCH indefinitely without alu_* changes.

Decomposition:
- Shared package: opcode constants (ALU_ADD, ALU_MUL, ALU_SUB, ALU_SFTR, ALU_SFTL), data width constant DATA_W=24, and the state encoding.
- Single module. No sub-module is natural. The bench instantiates the existing ALU alongside as the responder.

Test Plan:
- cmd_len=3, pairs (2,3),(4,5),(1,7), FIXED_POINT=0 -> res_data=33, res_zero=0, res_valid rises 10 cycles after cmd accept; alu_ctrl sequence MUL,ADD ×3.
- cmd_len=0 -> no elem_ready pulse, res_valid next cycle, res_data=0, res_zero=1.
- FIXED_POINT=1, cmd_len=2, pairs (0x000200,0x000300),(0x000100,0x000080) -> res_data=0x000680; SFTR issued after each MUL.
- Wrap: cmd_len=2, pairs (0x001000,0x001000),(0xFFFFFF,1) -> product 0x1000000 truncates to 0, total 0xFFFFFF; res_zero=0.
- Backpressure: elem_valid low 5 cycles mid-command, then res_ready held low 4 cycles -> alu_* stable while stalled, res_data stable, single result transfer, cmd_ready returns the cycle after.
- Async reset: drop rst_n during ADD of element 2 of 4 -> all outputs at reset values without a clock edge; a fresh cmd_len=1 (6,7) after release yields 42.
